// File: rtl/vend_transaction_ctrl.sv
// Single-transaction sequencer for a shape-coin vending machine: escrow, greedy change check, dispense/refund.
// Optional build macro CHANGE_LIMIT_EN: reject any change that would need more than two coins.
module vend_transaction_ctrl #(
  parameter int INV_W  = 2,
  parameter int INIT_P = 1,
  parameter int INIT_T = 1,
  parameter int INIT_C = 1
) (
  input  logic             clock,
  input  logic             reset_L,
  input  logic             cost_valid,
  input  logic [3:0]       cost,
  input  logic             cancel,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  output logic             coin_ready,
  output logic             coin_reject,
  output logic             dispense_valid,
  output logic [2:0]       dispense_coin,
  input  logic             dispense_ready,
  output logic             vend,
  output logic             no_change,
  output logic [3:0]       paid,
  output logic [3:0]       change_left,
  output logic [INV_W-1:0] inv_p,
  output logic [INV_W-1:0] inv_t,
  output logic [INV_W-1:0] inv_c,
  output logic             busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_COLLECT  = 3'd1;
  localparam logic [2:0] S_CHECK    = 3'd2;
  localparam logic [2:0] S_DISPENSE = 3'd3;
  localparam logic [2:0] S_REFUND   = 3'd4;

  localparam logic [INV_W:0] INV_MAX = {1'b0, {INV_W{1'b1}}};

  logic [2:0]       state;
  logic [3:0]       cost_r;
  logic [INV_W-1:0] esc_p, esc_t, esc_c;

  logic [INV_W:0]   avail_p, avail_t, avail_c, avail_sel;
  logic [2:0]       coin_val;
  logic             coin_ok, coin_accept;
  logic [3:0]       chg_amt;
  logic [7:0]       g_rem, g_p, g_t, g_c;
  logic             feasible;
  logic [2:0]       coin_sel;
  logic             take;
  logic [3:0]       chg_next;

  assign avail_p = {1'b0, inv_p} + {1'b0, esc_p};
  assign avail_t = {1'b0, inv_t} + {1'b0, esc_t};
  assign avail_c = {1'b0, inv_c} + {1'b0, esc_c};

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    coin_val  = 3'd0;
    avail_sel = '0;
    case (coin_type)
      2'b01: begin coin_val = 3'd1; avail_sel = avail_c; end
      2'b10: begin coin_val = 3'd3; avail_sel = avail_t; end
      2'b11: begin coin_val = 3'd5; avail_sel = avail_p; end
      default: ;
    endcase
  end

  // A coin fits only if the escrow value stays <= 15 and its slot (inventory + escrow) has room.
  assign coin_ok     = (coin_val != 3'd0) &&
                       (({1'b0, paid} + {2'b00, coin_val}) <= 5'd15) &&
                       (avail_sel < INV_MAX);
  assign coin_accept = (state == S_COLLECT) && coin_valid && !cancel && coin_ok;
  assign coin_reject = coin_valid && !coin_accept;

  assign chg_amt = paid - cost_r;

  // NOTE: blocking assignments here are intentional; g_rem is refined step by step within one evaluation.
  always_comb begin
    g_rem = 8'(chg_amt);
    g_p   = (8'(avail_p) < (g_rem / 8'd5)) ? 8'(avail_p) : (g_rem / 8'd5);
    g_rem = g_rem - g_p * 8'd5;
    g_t   = (8'(avail_t) < (g_rem / 8'd3)) ? 8'(avail_t) : (g_rem / 8'd3);
    g_rem = g_rem - g_t * 8'd3;
    g_c   = (8'(avail_c) < g_rem) ? 8'(avail_c) : g_rem;
    g_rem = g_rem - g_c;
`ifdef CHANGE_LIMIT_EN
    feasible = (g_rem == 8'd0) && ((g_p + g_t + g_c) <= 8'd2);
`else
    feasible = (g_rem == 8'd0);
`endif
  end

  // Dispense picks the largest coin that fits from inventory; refund empties escrow largest-first.
  always_comb begin
    coin_sel = 3'd0;
    if (state == S_DISPENSE) begin
      if (change_left >= 4'd5 && inv_p != '0)      coin_sel = 3'd5;
      else if (change_left >= 4'd3 && inv_t != '0) coin_sel = 3'd3;
      else if (change_left >= 4'd1 && inv_c != '0) coin_sel = 3'd1;
    end else if (state == S_REFUND) begin
      if (esc_p != '0)      coin_sel = 3'd5;
      else if (esc_t != '0) coin_sel = 3'd3;
      else if (esc_c != '0) coin_sel = 3'd1;
    end
  end

  assign dispense_valid = (coin_sel != 3'd0);
  assign dispense_coin  = coin_sel;
  assign take           = dispense_valid && dispense_ready;
  assign chg_next       = change_left - {1'b0, coin_sel};

  assign coin_ready = (state == S_COLLECT);
  assign vend       = (state == S_CHECK) && feasible;
  assign no_change  = (state == S_CHECK) && !feasible;
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      state       <= S_IDLE;
      cost_r      <= '0;
      paid        <= '0;
      change_left <= '0;
      esc_p       <= '0;
      esc_t       <= '0;
      esc_c       <= '0;
      inv_p       <= INV_W'(INIT_P);
      inv_t       <= INV_W'(INIT_T);
      inv_c       <= INV_W'(INIT_C);
    end else begin
      case (state)
        S_IDLE: begin
          if (cost_valid) begin
            cost_r <= cost;
            state  <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (cancel) begin
            change_left <= paid;
            state       <= (paid == 4'd0) ? S_IDLE : S_REFUND;
          end else begin
            if (coin_accept) begin
              paid <= paid + {1'b0, coin_val};
              case (coin_type)
                2'b01:   esc_c <= esc_c + INV_W'(1);
                2'b10:   esc_t <= esc_t + INV_W'(1);
                default: esc_p <= esc_p + INV_W'(1);
              endcase
            end
            if (paid >= cost_r) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (feasible) begin
            inv_p       <= inv_p + esc_p;
            inv_t       <= inv_t + esc_t;
            inv_c       <= inv_c + esc_c;
            esc_p       <= '0;
            esc_t       <= '0;
            esc_c       <= '0;
            change_left <= chg_amt;
            if (chg_amt == 4'd0) begin
              paid  <= '0;
              state <= S_IDLE;
            end else begin
              state <= S_DISPENSE;
            end
          end else begin
            change_left <= paid;
            state       <= S_REFUND;
          end
        end
        S_DISPENSE, S_REFUND: begin
          if (take) begin
            if (state == S_DISPENSE) begin
              case (coin_sel)
                3'd5:    inv_p <= inv_p - INV_W'(1);
                3'd3:    inv_t <= inv_t - INV_W'(1);
                default: inv_c <= inv_c - INV_W'(1);
              endcase
            end else begin
              case (coin_sel)
                3'd5:    esc_p <= esc_p - INV_W'(1);
                3'd3:    esc_t <= esc_t - INV_W'(1);
                default: esc_c <= esc_c - INV_W'(1);
              endcase
            end
            change_left <= chg_next;
            if (chg_next == 4'd0) begin
              paid  <= '0;
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_transaction_ctrl.sv
// Directed bench for vend_transaction_ctrl: per-cycle vector table plus hand-written corner sequences.
module tb_vend_transaction_ctrl;

  logic       clock = 1'b0;
  logic       reset_L;
  logic       cost_valid;
  logic [3:0] cost;
  logic       cancel;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       coin_reject;
  logic       dispense_valid;
  logic [2:0] dispense_coin;
  logic       dispense_ready;
  logic       vend;
  logic       no_change;
  logic [3:0] paid;
  logic [3:0] change_left;
  logic [1:0] inv_p, inv_t, inv_c;
  logic       busy;

  always #5 clock = ~clock;

  vend_transaction_ctrl #(.INV_W(2), .INIT_P(1), .INIT_T(1), .INIT_C(1)) dut (
    .clock(clock), .reset_L(reset_L), .cost_valid(cost_valid), .cost(cost), .cancel(cancel),
    .coin_valid(coin_valid), .coin_type(coin_type), .coin_ready(coin_ready), .coin_reject(coin_reject),
    .dispense_valid(dispense_valid), .dispense_coin(dispense_coin), .dispense_ready(dispense_ready),
    .vend(vend), .no_change(no_change), .paid(paid), .change_left(change_left),
    .inv_p(inv_p), .inv_t(inv_t), .inv_c(inv_c), .busy(busy)
  );

  typedef struct packed {
    logic       cv;
    logic [3:0] cost;
    logic       can;
    logic       coinv;
    logic [1:0] ct;
    logic       dr;
  } ins_t;

  typedef struct packed {
    logic       rdy, rej, dv;
    logic [2:0] dc;
    logic       vend, nc, busy;
    logic [3:0] paid, chg;
    logic [1:0] ip, it, ic;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t exp;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  int t4_ct[7]  = '{3, 3, 3, 3, 2, 1, 1};
  int t4_rej[7] = '{0, 0, 1, 1, 0, 0, 0};
  int n_out;
  int exp_coin[3];
  int exp_chg[3];
  outs_t t6_check, t6_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic ins_t mk(input int cv, input int cst, input int can, input int coinv,
                              input int ct, input int dr);
    ins_t i;
    i.cv = cv[0]; i.cost = cst[3:0]; i.can = can[0];
    i.coinv = coinv[0]; i.ct = ct[1:0]; i.dr = dr[0];
    return i;
  endfunction

  function automatic outs_t mko(input int rdy, input int rej, input int dv, input int dc,
                                input int vd, input int nc, input int bz, input int pd,
                                input int ch, input int ip, input int it, input int ic);
    outs_t o;
    o.rdy = rdy[0]; o.rej = rej[0]; o.dv = dv[0]; o.dc = dc[2:0];
    o.vend = vd[0]; o.nc = nc[0]; o.busy = bz[0];
    o.paid = pd[3:0]; o.chg = ch[3:0];
    o.ip = ip[1:0]; o.it = it[1:0]; o.ic = ic[1:0];
    return o;
  endfunction

  task automatic add(input int cv, input int cst, input int can, input int coinv, input int ct,
                     input int dr, input int rdy, input int rej, input int dv, input int dc,
                     input int vd, input int nc, input int bz, input int pd, input int ch,
                     input int ip, input int it, input int ic);
    vec_t v;
    v.in  = mk(cv, cst, can, coinv, ct, dr);
    v.exp = mko(rdy, rej, dv, dc, vd, nc, bz, pd, ch, ip, it, ic);
    vecs.push_back(v);
  endtask

  function automatic outs_t sample();
    return {coin_ready, coin_reject, dispense_valid, dispense_coin, vend, no_change, busy,
            paid, change_left, inv_p, inv_t, inv_c};
  endfunction

  task automatic drv(input ins_t i);
    cost_valid = i.cv; cost = i.cost; cancel = i.can;
    coin_valid = i.coinv; coin_type = i.ct; dispense_ready = i.dr;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drv(mk(0, 0, 0, 0, 0, 0));
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
  endtask

  initial begin
    // Test 1 + held-ready stall: cost 4, pentagon, change 1 circle.
    add(0,0,0,1,1,0, 0,1,0,0,0,0,0, 0,0, 1,1,1);
    add(1,4,0,0,0,0, 0,0,0,0,0,0,0, 0,0, 1,1,1);
    add(0,0,0,1,3,0, 1,0,0,0,0,0,1, 0,0, 1,1,1);
    add(0,0,0,0,0,0, 1,0,0,0,0,0,1, 5,0, 1,1,1);
    add(0,0,0,0,0,0, 0,0,0,0,1,0,1, 5,0, 1,1,1);
    for (int k = 0; k < 5; k++)
      add(0,0,0,0,0,0, 0,0,1,1,0,0,1, 5,1, 2,1,1);
    add(0,0,0,0,0,1, 0,0,1,1,0,0,1, 5,1, 2,1,1);
    add(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0, 2,1,0);
    // Test 2: cost 2, triangle, no circles left -> refund the triangle.
    add(1,2,0,0,0,0, 0,0,0,0,0,0,0, 0,0, 2,1,0);
    add(0,0,0,1,2,0, 1,0,0,0,0,0,1, 0,0, 2,1,0);
    add(0,0,0,0,0,0, 1,0,0,0,0,0,1, 3,0, 2,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,1,1, 3,0, 2,1,0);
    add(0,0,0,0,0,0, 0,0,1,3,0,0,1, 3,3, 2,1,0);
    add(0,0,0,0,0,1, 0,0,1,3,0,0,1, 3,3, 2,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0, 2,1,0);
    // Test 3: cost 7, invalid coin + stray cost, circle, cancel with a coin -> refund circle.
    add(1,7,0,0,0,0, 0,0,0,0,0,0,0, 0,0, 2,1,0);
    add(1,0,0,1,0,0, 1,1,0,0,0,0,1, 0,0, 2,1,0);
    add(0,0,0,1,1,0, 1,0,0,0,0,0,1, 0,0, 2,1,0);
    add(0,0,1,1,2,0, 1,1,0,0,0,0,1, 1,0, 2,1,0);
    add(0,0,0,0,0,1, 0,0,1,1,0,0,1, 1,1, 2,1,0);
    add(0,0,0,0,0,0, 0,0,0,0,0,0,0, 0,0, 2,1,0);

    drv(mk(0, 0, 0, 0, 0, 0));
    reset_L = 1'b0;
    tick();
    tick();
    @(negedge clock);
    check("reset_state", 32'(sample()), 32'(mko(0,0,0,0,0,0,0, 0,0, 1,1,1)));
    tick();
    reset_L = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drv(vecs[i].in);
      @(negedge clock);
      check($sformatf("vec%0d", i), 32'(sample()), 32'(vecs[i].exp));
      tick();
    end

    // Reset mid-transaction discards escrow without refunding.
    drv(mk(1, 9, 0, 0, 0, 0)); tick();
    drv(mk(0, 0, 0, 1, 3, 0)); tick();
    drv(mk(0, 0, 0, 0, 0, 1));
    @(negedge clock);
    check("pre_reset_paid", 32'(paid), 32'd5);
    reset_L = 1'b0;
    tick();
    @(negedge clock);
    check("mid_reset", 32'(sample()), 32'(mko(0,0,0,0,0,0,0, 0,0, 1,1,1)));
    reset_L = 1'b1;
    tick();

    // Test 4: cost 15, pentagon escrow fills, paid saturates at 15, vend with no change.
    drv(mk(1, 15, 0, 0, 0, 0)); tick();
    for (int i = 0; i < 7; i++) begin
      drv(mk(0, 0, 0, 1, t4_ct[i], 0));
      @(negedge clock);
      check($sformatf("t4_coin%0d_reject", i), 32'(coin_reject), 32'(t4_rej[i]));
      tick();
    end
    drv(mk(0, 0, 0, 1, 2, 0));
    @(negedge clock);
    check("t4_paid_max", 32'(sample()), 32'(mko(1,1,0,0,0,0,1, 15,0, 1,1,1)));
    tick();
    drv(mk(0, 0, 0, 0, 0, 1));
    @(negedge clock);
    check("t4_check", 32'(sample()), 32'(mko(0,0,0,0,1,0,1, 15,0, 1,1,1)));
    tick();
    @(negedge clock);
    check("t4_idle", 32'(sample()), 32'(mko(0,0,0,0,0,0,0, 0,0, 3,2,3)));
    tick();

    // Test 6: cost 1, two pentagons back to back -> change 9 (5+3+1 greedy).
    do_reset();
    drv(mk(1, 1, 0, 0, 0, 0)); tick();
    drv(mk(0, 0, 0, 1, 3, 0));
    @(negedge clock);
    check("t6_p1_reject", 32'(coin_reject), 32'd0);
    tick();
    drv(mk(0, 0, 0, 1, 3, 0));
    @(negedge clock);
    check("t6_p2", 32'({coin_reject, coin_ready, paid}), 32'({1'b0, 1'b1, 4'd5}));
    tick();
    drv(mk(0, 0, 0, 0, 0, 1));
`ifdef CHANGE_LIMIT_EN
    t6_check = mko(0,0,0,0,0,1,1, 10,0, 1,1,1);
    t6_end   = mko(0,0,0,0,0,0,0, 0,0, 1,1,1);
    n_out = 2;
    exp_coin = '{5, 5, 0};
    exp_chg  = '{10, 5, 0};
`else
    t6_check = mko(0,0,0,0,1,0,1, 10,0, 1,1,1);
    t6_end   = mko(0,0,0,0,0,0,0, 0,0, 2,0,0);
    n_out = 3;
    exp_coin = '{5, 3, 1};
    exp_chg  = '{9, 4, 1};
`endif
    @(negedge clock);
    check("t6_check", 32'(sample()), 32'(t6_check));
    tick();
    for (int i = 0; i < n_out; i++) begin
      @(negedge clock);
      check($sformatf("t6_out%0d", i), 32'({dispense_valid, dispense_coin, change_left}),
            32'({1'b1, 3'(exp_coin[i]), 4'(exp_chg[i])}));
      tick();
    end
    @(negedge clock);
    check("t6_idle", 32'(sample()), 32'(t6_end));
    tick();

    // Cost 0 goes COLLECT -> CHECK -> IDLE with a vend and nothing dispensed.
    drv(mk(1, 0, 0, 0, 0, 0)); tick();
    drv(mk(0, 0, 0, 0, 0, 1));
    @(negedge clock);
    check("cost0_collect", 32'({coin_ready, vend, busy}), 32'(3'b101));
    tick();
    @(negedge clock);
    check("cost0_check", 32'({vend, no_change, busy, dispense_valid}), 32'(4'b1010));
    tick();
    @(negedge clock);
    check("cost0_idle", 32'({busy, dispense_valid}), 32'(2'b00));

    // Cancel with nothing paid returns straight to IDLE.
    drv(mk(1, 5, 0, 0, 0, 0)); tick();
    drv(mk(0, 0, 1, 0, 0, 1));
    @(negedge clock);
    check("cancel0_collect", 32'(coin_ready), 32'd1);
    tick();
    drv(mk(0, 0, 0, 0, 0, 1));
    @(negedge clock);
    check("cancel0_idle", 32'({busy, dispense_valid, change_left}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
